// File: rtl/ipi_pkg.sv
// Shared IPI mailbox definitions: CSR window offsets used by both the agent and the
// mailbox, plus the agent FSM state encoding.
package ipi_pkg;

    localparam logic [31:0] IPI_OFF_SEND_MASK = 32'h0;
    localparam logic [31:0] IPI_OFF_TX_DATA   = 32'h4;
    localparam logic [31:0] IPI_OFF_RX_DATA   = 32'h8;
    localparam logic [31:0] IPI_OFF_STATUS    = 32'hC;

    typedef logic [2:0] ipi_agent_state_e;

    localparam ipi_agent_state_e StIdle    = 3'd0;
    localparam ipi_agent_state_e StMaskReq = 3'd1;
    localparam ipi_agent_state_e StMaskRsp = 3'd2;
    localparam ipi_agent_state_e StTxReq   = 3'd3;
    localparam ipi_agent_state_e StTxRsp   = 3'd4;
    localparam ipi_agent_state_e StRxReq   = 3'd5;
    localparam ipi_agent_state_e StRxRsp   = 3'd6;

endpackage

// File: rtl/csr_if.sv
// Simple valid/ready CSR bus: one request channel (addr/write/wdata) and one
// response channel (rdata/fault).
interface csr_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_fault;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_fault, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_fault, rsp_rdata
    );
endinterface

// File: rtl/ipi_mailbox_agent.sv
// Per-core IPI mailbox initiator: turns send commands into SEND_MASK/TX_DATA writes and
// drains RX_DATA on ipi_irq. Optional mask cache: define IPI_AGENT_MASK_CACHE_EN.
module ipi_mailbox_agent
    import ipi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned CORES     = 2,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    csr_if.master             csr,
    input  logic              ipi_irq,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [CORES-1:0]  tx_mask,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              fault,
    output logic [7:0]        fault_cnt,
    output logic              busy
);

    localparam int unsigned AddrW = $bits(csr.req_addr);
    localparam logic [31:0] MaskAddr = BASE_ADDR + IPI_OFF_SEND_MASK;
    localparam logic [31:0] TxAddr   = BASE_ADDR + IPI_OFF_TX_DATA;
    localparam logic [31:0] RxAddr   = BASE_ADDR + IPI_OFF_RX_DATA;

    ipi_agent_state_e state_q, state_d;

    logic              req_valid_q;
    logic              req_write_q;
    logic [AddrW-1:0]  req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              fault_q;
    logic [7:0]        fault_cnt_q;
    logic              last_rx_q;

    logic idle;
    logic rx_elig;
    logic grant_rx;
    logic grant_tx;
    logic skip_mask;
    logic in_rsp;
    logic req_hs;
    logic rsp_hs;
    logic mask_done;

    assign idle      = (state_q == StIdle);
    assign rx_elig   = ipi_irq && !rx_valid_q;
    // On contention RX wins unless the previous grant was already RX.
    assign grant_rx  = idle && rx_elig && (!tx_valid || !last_rx_q);
    assign grant_tx  = idle && tx_valid && !grant_rx;
    assign in_rsp    = (state_q == StMaskRsp) || (state_q == StTxRsp) || (state_q == StRxRsp);
    assign req_hs    = req_valid_q && csr.req_ready;
    assign rsp_hs    = in_rsp && csr.rsp_valid;
    assign mask_done = (state_q == StMaskRsp) && csr.rsp_valid;

`ifdef IPI_AGENT_MASK_CACHE_EN
    logic [CORES-1:0] mask_q;
    logic [CORES-1:0] cache_mask_q;
    logic             cache_vld_q;

    assign skip_mask = cache_vld_q && (tx_mask == cache_mask_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q       <= '0;
            cache_mask_q <= '0;
            cache_vld_q  <= 1'b0;
        end else begin
            if (grant_tx) begin
                mask_q <= tx_mask;
            end
            if (mask_done) begin
                if (csr.rsp_fault) begin
                    cache_vld_q <= 1'b0;
                end else begin
                    cache_mask_q <= mask_q;
                    cache_vld_q  <= 1'b1;
                end
            end
        end
    end
`else
    assign skip_mask = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_rx) begin
                    state_d = StRxReq;
                end else if (grant_tx) begin
                    state_d = skip_mask ? StTxReq : StMaskReq;
                end
            end
            StMaskReq: if (req_hs) state_d = StMaskRsp;
            StMaskRsp: if (csr.rsp_valid) state_d = StTxReq;
            StTxReq:   if (req_hs) state_d = StTxRsp;
            StTxRsp:   if (csr.rsp_valid) state_d = StIdle;
            StRxReq:   if (req_hs) state_d = StRxRsp;
            StRxRsp:   if (csr.rsp_valid) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request registers are loaded on the transition into a *_REQ state and held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            data_q      <= '0;
        end else begin
            if (req_hs) begin
                req_valid_q <= 1'b0;
            end
            if (grant_rx) begin
                req_valid_q <= 1'b1;
                req_write_q <= 1'b0;
                req_addr_q  <= RxAddr[AddrW-1:0];
                req_wdata_q <= '0;
            end else if (grant_tx) begin
                data_q      <= tx_data;
                req_valid_q <= 1'b1;
                req_write_q <= 1'b1;
                if (skip_mask) begin
                    req_addr_q  <= TxAddr[AddrW-1:0];
                    req_wdata_q <= tx_data;
                end else begin
                    req_addr_q  <= MaskAddr[AddrW-1:0];
                    req_wdata_q <= DATA_W'(tx_mask);
                end
            end else if (mask_done) begin
                req_valid_q <= 1'b1;
                req_write_q <= 1'b1;
                req_addr_q  <= TxAddr[AddrW-1:0];
                req_wdata_q <= data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            fault_q     <= 1'b0;
            fault_cnt_q <= '0;
            last_rx_q   <= 1'b0;
        end else begin
            fault_q <= rsp_hs && csr.rsp_fault;
            if (rsp_hs && csr.rsp_fault && (fault_cnt_q != 8'hFF)) begin
                fault_cnt_q <= fault_cnt_q + 8'd1;
            end
            // A faulted RX read means the remote FIFO was empty; nothing to deliver.
            if ((state_q == StRxRsp) && csr.rsp_valid && !csr.rsp_fault) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= csr.rsp_rdata;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (grant_rx) begin
                last_rx_q <= 1'b1;
            end else if (grant_tx) begin
                last_rx_q <= 1'b0;
            end
        end
    end

    assign csr.req_valid = req_valid_q;
    assign csr.req_write = req_write_q;
    assign csr.req_addr  = req_addr_q;
    assign csr.req_wdata = req_wdata_q;
    assign csr.rsp_ready = in_rsp;

    assign tx_ready  = grant_tx;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign fault     = fault_q;
    assign fault_cnt = fault_cnt_q;
    assign busy      = !idle;

endmodule

// File: tb/tb_ipi_mailbox_agent.sv
// Directed bench for ipi_mailbox_agent against a behavioural zero-wait mailbox with
// stall/fault injection and a per-cycle output model.
module tb_ipi_mailbox_agent;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    logic        ipi_irq, tx_valid, tx_ready, rx_valid, rx_ready, fault, busy;
    logic [1:0]  tx_mask;
    logic [31:0] tx_data, rx_data;
    logic [7:0]  fault_cnt;

    ipi_mailbox_agent #(.BASE_ADDR(32'h0), .CORES(2), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .csr       (bus),
        .ipi_irq   (ipi_irq),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_mask   (tx_mask),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .fault     (fault),
        .fault_cnt (fault_cnt),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected event within bound", name);
    endtask

    typedef struct packed {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
    } txn_t;

    function automatic logic [63:0] txn(input logic w, input logic [11:0] a, input logic [31:0] d);
        return {19'b0, w, a, d};
    endfunction

    // Mailbox model: accepts a request, answers on the following cycle.
    txn_t        log_q[$];
    int          stall_left  = 0;
    logic [11:0] stall_addr  = 12'h0;
    logic        mb_fault    = 1'b0;
    logic [31:0] mb_rdata    = 32'h0;
    int          stall_cycles = 0;
    int          faulted_rsps = 0;

    bit   s_rst, s_req, s_rsp;
    txn_t s_txn;

    initial begin
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_fault = 1'b0;
        bus.rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_req = bus.req_valid && bus.req_ready;
            s_rsp = bus.rsp_valid && bus.rsp_ready;
            s_txn = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
            @(posedge clk);
            #1;
            if (s_rst) begin
                bus.rsp_valid = 1'b0;
                stall_left    = 0;
            end else begin
                if (s_rsp) bus.rsp_valid = 1'b0;
                if (s_req) begin
                    log_q.push_back(s_txn);
                    bus.rsp_valid = 1'b1;
                    bus.rsp_fault = mb_fault;
                    bus.rsp_rdata = s_txn.write ? 32'h0 : mb_rdata;
                end
            end
            if (bus.req_valid && bus.req_addr == stall_addr && stall_left > 0) begin
                bus.req_ready = 1'b0;
                stall_left--;
            end else begin
                bus.req_ready = 1'b1;
            end
        end
    end

    // Output model from observed bus traffic, compared every cycle after reset.
    initial begin
        bit          armed = 0, e_fault = 0, e_rxv = 0, pend_read = 0, hold = 0;
        logic [7:0]  e_cnt = 0;
        logic [31:0] e_rxd = 0;
        logic [63:0] held = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 1; e_fault = 0; e_cnt = 0; e_rxv = 0; e_rxd = 0;
                pend_read = 0; hold = 0;
                continue;
            end
            if (!armed) continue;
            check("fault", 64'(fault), 64'(e_fault));
            check("fault_cnt", 64'(fault_cnt), 64'(e_cnt));
            check("rx_valid", 64'(rx_valid), 64'(e_rxv));
            check("rx_data", 64'(rx_data), 64'(e_rxd));
            if (hold) begin
                check("req_hold", {18'b0, bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata},
                      held);
            end
            if (bus.req_valid && !bus.req_ready) stall_cycles++;
            hold = bus.req_valid && !bus.req_ready;
            held = {18'b0, 1'b1, bus.req_write, bus.req_addr, bus.req_wdata};
            e_fault = 0;
            if (e_rxv && rx_ready) e_rxv = 0;
            if (bus.req_valid && bus.req_ready) pend_read = !bus.req_write;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (bus.rsp_fault) begin
                    e_fault = 1;
                    faulted_rsps++;
                    if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
                end else if (pend_read) begin
                    e_rxv = 1;
                    e_rxd = bus.rsp_rdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] d, output int lat);
        bit got = 0;
        lat = -1;
        tick();
        tx_valid = 1'b1;
        tx_mask  = m;
        tx_data  = d;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1;
        end
        if (!got) begin
            fail_now("tx_grant");
            tick();
            tx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        check("tx_ready_pulse", 64'(tx_ready), 64'(0));
        tick();
        tx_valid = 1'b0;
        for (int c = 2; c < 100; c++) begin
            @(negedge clk);
            if (!busy) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) fail_now("tx_done");
    endtask

    task automatic check_txn(input string name, input int idx, input logic w,
                             input logic [11:0] a, input logic [31:0] d);
        if (idx < log_q.size()) check(name, txn(log_q[idx].write, log_q[idx].addr,
                                                log_q[idx].wdata), txn(w, a, d));
        else fail_now(name);
    endtask

    task automatic wait_quiet(input string name);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !rx_valid) ok = 1;
        end
        if (!ok) fail_now(name);
    endtask

    initial begin
        int lat;
        bit got;
        bit ops[$];
        bit exp_alt[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; ipi_irq = 1'b0; tx_valid = 1'b0; tx_mask = 2'b0; tx_data = 32'h0;
        rx_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_req_valid", 64'(bus.req_valid), 64'(0));
        check("rst_rsp_ready", 64'(bus.rsp_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_tx_ready", 64'(tx_ready), 64'(0));
        check("rst_rx_valid", 64'(rx_valid), 64'(0));
        check("rst_rx_data", 64'(rx_data), 64'(0));
        check("rst_fault_cnt", 64'(fault_cnt), 64'(0));
        tick();
        rst = 1'b0;

        // First send always writes the mask.
        log_q.delete();
        send(2'b10, 32'hDEAD_BEEF, lat);
        check("tx1_latency", 64'(lat), 64'(5));
        check("tx1_count", 64'(log_q.size()), 64'(2));
        check_txn("tx1_mask", 0, 1'b1, 12'h000, 32'h2);
        check_txn("tx1_data", 1, 1'b1, 12'h004, 32'hDEAD_BEEF);

        log_q.delete();
        send(2'b10, 32'hDEAD_BEEF, lat);
`ifdef IPI_AGENT_MASK_CACHE_EN
        check("tx2_latency", 64'(lat), 64'(3));
        check("tx2_count", 64'(log_q.size()), 64'(1));
        check_txn("tx2_data", 0, 1'b1, 12'h004, 32'hDEAD_BEEF);
`else
        check("tx2_latency", 64'(lat), 64'(5));
        check("tx2_count", 64'(log_q.size()), 64'(2));
        check_txn("tx2_mask", 0, 1'b1, 12'h000, 32'h2);
`endif

        // Four-cycle stall on TX_DATA.
        log_q.delete();
        stall_cycles = 0;
        stall_addr = 12'h004;
        stall_left = 4;
        send(2'b01, 32'hA5A5_0001, lat);
        check("stall_latency", 64'(lat), 64'(9));
        check("stall_cycles", 64'(stall_cycles), 64'(4));
        check("stall_count", 64'(log_q.size()), 64'(2));
        check_txn("stall_data", 1, 1'b1, 12'h004, 32'hA5A5_0001);

        // Contention: last grant was TX, so RX goes first and they alternate.
        log_q.delete();
        mb_rdata = 32'h55;
        tick();
        rx_ready = 1'b1; tx_valid = 1'b1; tx_mask = 2'b01; tx_data = 32'h77; ipi_irq = 1'b1;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            ops.delete();
            foreach (log_q[k]) begin
                if (!log_q[k].write) ops.push_back(1'b1);
                else if (log_q[k].addr == 12'h004) ops.push_back(1'b0);
            end
            if (ops.size() >= 4) got = 1;
        end
        tick();
        tx_valid = 1'b0; ipi_irq = 1'b0;
        wait_quiet("alt_quiet");
        for (int k = 0; k < 4; k++) begin
            if (k < ops.size()) check($sformatf("alt_op%0d", k), 64'(ops[k]), 64'(exp_alt[k]));
            else fail_now("alt_ops");
        end

        // Single RX with consumer stalled.
        log_q.delete();
        rx_ready = 1'b0;
        mb_rdata = 32'h1234;
        tick();
        ipi_irq = 1'b1;
        lat = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rx_valid) begin
                lat = c;
                break;
            end
        end
        check("rx_latency", 64'(lat), 64'(3));
        check("rx_data_val", 64'(rx_data), 64'h1234);
        repeat (8) @(negedge clk);
        check("rx_single_read", 64'(log_q.size()), 64'(1));
        check_txn("rx_read", 0, 1'b0, 12'h008, 32'h0);
        check("rx_held", 64'(rx_valid), 64'(1));
        check("rx_idle", 64'(busy), 64'(0));
        tick();
        ipi_irq = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        tick();
        rx_ready = 1'b0;
        @(negedge clk);
        check("rx_drained", 64'(rx_valid), 64'(0));

        // Faulted RX read.
        mb_fault = 1'b1;
        tick();
        ipi_irq = 1'b1;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_fault) got = 1;
        end
        if (!got) fail_now("rx_fault_rsp");
        tick();
        ipi_irq = 1'b0;
        @(negedge clk);
        check("fault_pulse", 64'(fault), 64'(1));
        check("fault_cnt_1", 64'(fault_cnt), 64'(1));
        check("fault_no_rx", 64'(rx_valid), 64'(0));
        @(negedge clk);
        check("fault_pulse_end", 64'(fault), 64'(0));

        // Saturation after 300 faults.
        tick();
        ipi_irq = 1'b1;
        for (int i = 0; i < 3000 && faulted_rsps < 300; i++) @(negedge clk);
        if (faulted_rsps < 300) fail_now("fault_300");
        tick();
        ipi_irq = 1'b0;
        wait_quiet("sat_quiet");
        check("fault_cnt_sat", 64'(fault_cnt), 64'(255));

        // Faulted mask write still proceeds; the following send rewrites the mask.
        log_q.delete();
        send(2'b11, 32'h1, lat);
        check("fmask_latency", 64'(lat), 64'(5));
        check("fmask_count", 64'(log_q.size()), 64'(2));
        mb_fault = 1'b0;
        send(2'b11, 32'h2, lat);
        check("fmask_rewrite", 64'(lat), 64'(5));

        // Reset while stalled in TX_REQ.
        send(2'b01, 32'h3, lat);
        log_q.delete();
        stall_addr = 12'h004;
        stall_left = 50;
        tick();
        tx_valid = 1'b1; tx_mask = 2'b01; tx_data = 32'h4;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1;
        end
        tick();
        tx_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.req_valid && bus.req_addr == 12'h004 && !bus.req_ready) got = 1;
        end
        if (!got) fail_now("reach_tx_req");
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req_valid", 64'(bus.req_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        log_q.delete();
        send(2'b01, 32'h4, lat);
        check("post_rst_latency", 64'(lat), 64'(5));
        check_txn("post_rst_mask", 0, 1'b1, 12'h000, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ipi_mailbox_agent.md
# ipi_mailbox_agent

Per-core initiator for the IPI mailbox CSR window. It turns a simple command stream (send mask + data word) into CSR transactions toward the mailbox. When the core's `ipi_irq` is asserted, it drains received words into an output stream. It sits between a core-side producer/consumer (DMA engine, microsequencer or test master) and that core's `csr_if` port on the mailbox.

## Interface
- `BASE_ADDR`, 0, byte address of the mailbox window for this core; `req_addr` = `BASE_ADDR` + offset, truncated to the `csr_if` address width.
- `CORES`, 2, width of the target mask.
- `DATA_W`, 32, mailbox word width.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `csr`  `csr_if.master`  —  CSR initiator port toward the mailbox.
- `ipi_irq`  in  1  level from mailbox; this core's RX FIFO is non-empty.
- `tx_valid`  in  1  send command valid.
- `tx_ready`  out  1  send command accepted.
- `tx_mask`  in  CORES  target set.
- `tx_data`  in  DATA_W  word to send.
- `rx_valid`  out  1  received word available.
- `rx_ready`  in  1  consumer accepts received word.
- `rx_data`  out  DATA_W  received word.
- `fault`  out  1  one-cycle pulse on any response with `rsp_fault`=1.
- `fault_cnt`  out  8  saturating count of faulted responses.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Offsets are fixed: SEND_MASK 0x0, TX_DATA 0x4, RX_DATA 0x8, STATUS 0xC. STATUS is never issued.
- FSM states:
  - IDLE.
  - MASK_REQ, MASK_RSP.
  - TX_REQ, TX_RSP.
  - RX_REQ, RX_RSP.
- Only one CSR transaction is outstanding at any time.
- Arbitration in IDLE:
  - RX eligible = `ipi_irq` && !`rx_valid`.
  - TX eligible = `tx_valid`.
  - If both are eligible, priority alternates through `last_rx_q`: RX wins unless the previous granted operation was RX. This prevents starvation in both directions and avoids deadlock against a full local RX FIFO.
- TX grant:
  - `tx_ready`=1 for that cycle; `tx_mask` and `tx_data` are captured.
  - Next state is MASK_REQ, or TX_REQ when the mask write is skipped (see Configuration).
- MASK_REQ drives a write to SEND_MASK with wdata = zero-extended mask.
- TX_REQ drives a write to TX_DATA with wdata = captured data.
- RX_REQ drives a read of RX_DATA with wdata = 0.
- *_REQ → *_RSP on `req_valid && req_ready`.
- *_RSP states:
  - `rsp_ready`=1; the response is consumed on `rsp_valid`.
  - MASK_RSP → TX_REQ.
  - TX_RSP → IDLE.
  - RX_RSP → IDLE. On a non-fault response, `rx_data` ← `rsp_rdata` and `rx_valid` ← 1. On a faulted response (FIFO empty), the word is dropped.
- Any response with `rsp_fault`=1:
  - pulses `fault`;
  - increments `fault_cnt`, saturating at 255;
  - does not abort the sequence. A faulted MASK write still proceeds to TX_DATA.
- `rx_valid` clears on `rx_valid && rx_ready`.
- The RX output register holds a single entry. RX is not eligible while it is full.

## Timing
- Reset values:
  - state IDLE;
  - `req_valid`, `rsp_ready`, `tx_ready`, `rx_valid`, `fault`, `busy` = 0;
  - `fault_cnt` = 0, `rx_data` = 0, mask cache invalid, `last_rx_q` = 0.
- All CSR request outputs are registered. `req_valid` stays asserted, with stable addr/write/wdata, until `req_ready` is seen; it is never withdrawn.
- `rsp_ready` is high only in *_RSP states. It is a combinational decode of the registered state.
- Latency against a zero-wait mailbox, with a grant at cycle 0:
  - TX, mask skipped: `req_valid` at cycle 1, response at cycle 2, IDLE at cycle 3.
  - TX with mask write: IDLE at cycle 5.
  - RX: `rx_valid` at cycle 3.
- Back-to-back: IDLE can grant in the same cycle it is re-entered.
- `ipi_irq` is sampled only in IDLE. Because it is one cycle stale after a pop, the arbiter grants RX only after RX_RSP has completed.
- `tx_valid` dropping without a handshake has no effect.
- Reset asserted mid-transaction:
  - returns to IDLE next cycle;
  - drops `req_valid` and invalidates the mask cache;
  - the mailbox shares this reset domain.

## Configuration
- `IPI_AGENT_MASK_CACHE_EN` defined:
  - The agent keeps the last successfully written mask and a valid bit.
  - On a TX grant, if the valid bit is set and `tx_mask` equals the cached mask, the agent goes straight to TX_REQ.
  - A faulted mask write clears the valid bit.
- Not defined: every TX issues a SEND_MASK write, and no cache registers are present.

## Structure
- Package `ipi_pkg` holds:
  - the offset constants `IPI_OFF_SEND_MASK`, `IPI_OFF_TX_DATA`, `IPI_OFF_RX_DATA`, `IPI_OFF_STATUS`;
  - `ipi_agent_state_e`.
- The mailbox imports the same offsets.
- Single module, no sub-module. The RX output register and arbiter are inline.

## Test plan
- Against a zero-wait mailbox:
  - tx mask=2'b10, data=0xDEAD_BEEF → SEND_MASK write 0x2, then TX_DATA write 0xDEADBEEF; `tx_ready` high 1 cycle; IDLE at cycle 5.
  - A second identical send, with the macro defined → only the TX_DATA write; done at cycle 3. Without the macro → both writes again.
- Mailbox holds `req_ready`=0 for 4 cycles on TX_DATA → `req_valid`/addr/wdata stable all 4 cycles; exactly one write is issued.
- `ipi_irq`=1, mailbox returns 0x1234 → read of offset 0x8; `rx_valid`=1 with `rx_data`=0x1234; with `rx_ready`=0 there is no second read even though irq stays high.
- `tx_valid` and `ipi_irq` held continuously for 4 operations → grants alternate RX, TX, RX, TX.
- RX_DATA response with fault=1 → `fault` pulse, `fault_cnt`=1, `rx_valid` stays 0. After 300 faults, `fault_cnt`=255.
- `rst` asserted while in TX_REQ → next cycle `req_valid`=0, `busy`=0; the next identical send rewrites SEND_MASK.
